// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: depth and pointer-width derivation, binary-to-Gray encode.
// Pure declarations; no state.
package fifo_pkg;

   function automatic int depth(input int addrsize);
      return 1 << addrsize;
   endfunction

   // Pointers carry one extra MSB so full and empty are distinguishable.
   function automatic int ptr_w(input int addrsize);
      return addrsize + 1;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return (bin >> 1) ^ bin;
   endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary converter, combinational XOR prefix from the MSB down.
// Zero latency; no flow control.
module gray2bin #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^gray[WIDTH-1:i];
   end

endmodule

// File: rtl/wptr_full_prog.sv
// Write-domain pointer, full, almost-full, fill level and sticky overflow for the async FIFO.
// Flags/level register on the accepting edge; writes while full are dropped and flagged.
module wptr_full_prog
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE = 4
) (
   input  logic                  wclk_i,
   input  logic                  wrst_i,
   input  logic                  winc_i,
   input  logic [ADDRSIZE:0]     wq2_rptr_i,
   input  logic [ADDRSIZE:0]     wafull_thr_i,
   input  logic                  wclr_ovf_i,
   output logic [ADDRSIZE:0]     wptr_o,
   output logic [ADDRSIZE-1:0]   waddr_o,
   output logic                  wfull_o,
   output logic                  w_almost_full_o,
   output logic [ADDRSIZE:0]     wcount_o,
   output logic                  wovf_o
);

   localparam int               PTR_W   = ptr_w(ADDRSIZE);
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(depth(ADDRSIZE));

   logic [PTR_W-1:0] wbin;
   logic [PTR_W-1:0] wbinnext;
   logic [PTR_W-1:0] wgraynext;
   logic [PTR_W-1:0] rbin;
   logic [PTR_W-1:0] lvl_next;
   logic [PTR_W-1:0] thr_eff;
   logic             full_next;
   logic             afull_next;

   gray2bin #(.WIDTH(PTR_W)) u_rptr_g2b (
      .gray (wq2_rptr_i),
      .bin  (rbin)
   );

   always_comb begin
      wbinnext   = wbin + PTR_W'(winc_i & ~wfull_o);
      wgraynext  = PTR_W'(bin2gray(32'(wbinnext)));
      lvl_next   = wbinnext - rbin;
      // Full when the write pointer is exactly one lap ahead of the read pointer.
      full_next  = (wgraynext == {~wq2_rptr_i[PTR_W-1:PTR_W-2], wq2_rptr_i[PTR_W-3:0]});
      thr_eff    = (wafull_thr_i > DEPTH_P) ? DEPTH_P : wafull_thr_i;
      afull_next = (thr_eff != '0) && (lvl_next >= thr_eff);
   end

   always_ff @(posedge wclk_i or posedge wrst_i) begin
      if (wrst_i) begin
         wbin            <= '0;
         wptr_o          <= '0;
         wfull_o         <= 1'b0;
         w_almost_full_o <= 1'b0;
         wcount_o        <= '0;
         wovf_o          <= 1'b0;
      end else begin
         wbin            <= wbinnext;
         wptr_o          <= wgraynext;
         wfull_o         <= full_next;
         w_almost_full_o <= afull_next;
         wcount_o        <= lvl_next;
         // Set has priority over clear so a same-cycle dropped write is never lost.
         if (winc_i && wfull_o)
            wovf_o <= 1'b1;
         else if (wclr_ovf_i)
            wovf_o <= 1'b0;
      end
   end

   assign waddr_o = wbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_wptr_full_prog.sv
// Directed bench for wptr_full_prog with ADDRSIZE=4; inputs change and outputs are sampled on negedge.
module tb_wptr_full_prog;

   logic       wclk = 1'b0;
   logic       wrst = 1'b0;
   logic       winc = 1'b0;
   logic [4:0] wq2_rptr = '0;
   logic [4:0] wafull_thr = 5'd16;
   logic       wclr_ovf = 1'b0;
   logic [4:0] wptr;
   logic [3:0] waddr;
   logic       wfull;
   logic       w_almost_full;
   logic [4:0] wcount;
   logic       wovf;

   int checks = 0;
   int errors = 0;

   wptr_full_prog #(.ADDRSIZE(4)) dut (
      .wclk_i          (wclk),
      .wrst_i          (wrst),
      .winc_i          (winc),
      .wq2_rptr_i      (wq2_rptr),
      .wafull_thr_i    (wafull_thr),
      .wclr_ovf_i      (wclr_ovf),
      .wptr_o          (wptr),
      .waddr_o         (waddr),
      .wfull_o         (wfull),
      .w_almost_full_o (w_almost_full),
      .wcount_o        (wcount),
      .wovf_o          (wovf)
   );

   always #5 wclk = ~wclk;

   task automatic do_reset();
      wrst = 1'b1;
      winc = 1'b0;
      wclr_ovf = 1'b0;
      wq2_rptr = '0;
      @(negedge wclk);
      wrst = 1'b0;
   endtask

   task automatic write_n(input int n);
      winc = 1'b1;
      repeat (n) @(negedge wclk);
      winc = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] exp_ptr [5] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110};
      winc = 1'b1;
      #2 wrst = 1'b1;
      repeat (2) @(negedge wclk);
      checks++;
      if ({wptr, waddr, wfull, w_almost_full, wcount, wovf} !== 17'd0) begin
         errors++;
         $display("FAIL reset_zero: got %b required all zero", {wptr, waddr, wfull, w_almost_full, wcount, wovf});
      end
      wrst = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (wptr !== exp_ptr[i] || waddr !== 4'(i)) begin
            errors++;
            $display("FAIL ptr_step%0d: got wptr=%b waddr=%0d required wptr=%b waddr=%0d", i, wptr, waddr, exp_ptr[i], i);
         end
         if (i < 4) @(negedge wclk);
      end
      winc = 1'b0;
   endtask

   task automatic test_fill();
      wafull_thr = 5'd16;
      winc = 1'b1;
      for (int n = 5; n <= 16; n++) begin
         @(negedge wclk);
         checks++;
         if (wcount !== 5'(n) || wfull !== (n == 16) || w_almost_full !== (n == 16)) begin
            errors++;
            $display("FAIL fill_%0d: got count=%0d full=%b af=%b required count=%0d full=%b af=%b",
                     n, wcount, wfull, w_almost_full, n, n == 16, n == 16);
         end
      end
      checks++;
      if (wptr !== 5'b11000 || waddr !== 4'd0) begin
         errors++;
         $display("FAIL full_ptr: got wptr=%b waddr=%0d required 11000 0", wptr, waddr);
      end
   endtask

   task automatic test_overflow();
      winc = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge wclk);
         checks++;
         if (wptr !== 5'b11000 || wovf !== 1'b1 || wcount !== 5'd16) begin
            errors++;
            $display("FAIL ovf_hold%0d: got wptr=%b ovf=%b count=%0d required 11000 1 16", i, wptr, wovf, wcount);
         end
      end
      winc = 1'b0;
      wclr_ovf = 1'b1;
      @(negedge wclk);
      checks++;
      if (wovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: got %b required 0", wovf);
      end
      winc = 1'b1;
      @(negedge wclk);
      checks++;
      if (wovf !== 1'b1 || wptr !== 5'b11000) begin
         errors++;
         $display("FAIL ovf_set_wins: got ovf=%b wptr=%b required 1 11000", wovf, wptr);
      end
      winc = 1'b0;
      wclr_ovf = 1'b0;
   endtask

   task automatic test_threshold();
      wafull_thr = 5'd12;
      do_reset();
      write_n(11);
      checks++;
      if (w_almost_full !== 1'b0 || wcount !== 5'd11) begin
         errors++;
         $display("FAIL thr12_at11: got af=%b count=%0d required 0 11", w_almost_full, wcount);
      end
      write_n(1);
      checks++;
      if (w_almost_full !== 1'b1 || wcount !== 5'd12) begin
         errors++;
         $display("FAIL thr12_at12: got af=%b count=%0d required 1 12", w_almost_full, wcount);
      end
      wafull_thr = 5'd0;
      do_reset();
      write_n(16);
      checks++;
      if (w_almost_full !== 1'b0 || wfull !== 1'b1) begin
         errors++;
         $display("FAIL thr0: got af=%b full=%b required 0 1", w_almost_full, wfull);
      end
      wafull_thr = 5'd31;
      do_reset();
      write_n(15);
      checks++;
      if (w_almost_full !== 1'b0) begin
         errors++;
         $display("FAIL thr31_at15: got af=%b required 0", w_almost_full);
      end
      write_n(1);
      checks++;
      if (w_almost_full !== 1'b1 || wcount !== 5'd16) begin
         errors++;
         $display("FAIL thr31_at16: got af=%b count=%0d required 1 16", w_almost_full, wcount);
      end
      wafull_thr = 5'd16;
   endtask

   task automatic test_wrap();
      do_reset();
      write_n(16);
      wq2_rptr = 5'b11000;
      @(negedge wclk);
      checks++;
      if (wfull !== 1'b0 || wcount !== 5'd0) begin
         errors++;
         $display("FAIL drain: got full=%b count=%0d required 0 0", wfull, wcount);
      end
      write_n(16);
      checks++;
      if (wptr !== 5'b00000 || wfull !== 1'b1 || wcount !== 5'd16 || waddr !== 4'd0) begin
         errors++;
         $display("FAIL wrap: got wptr=%b full=%b count=%0d waddr=%0d required 00000 1 16 0", wptr, wfull, wcount, waddr);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      write_n(7);
      checks++;
      if (wcount !== 5'd7) begin
         errors++;
         $display("FAIL pre_reset_count: got %0d required 7", wcount);
      end
      #2 wrst = 1'b1;
      #1;
      checks++;
      if ({wptr, waddr, wfull, w_almost_full, wcount, wovf} !== 17'd0) begin
         errors++;
         $display("FAIL async_reset: got %b required all zero", {wptr, waddr, wfull, w_almost_full, wcount, wovf});
      end
      @(negedge wclk);
      wrst = 1'b0;
      write_n(3);
      checks++;
      if (wcount !== 5'd3 || waddr !== 4'd3) begin
         errors++;
         $display("FAIL post_reset: got count=%0d waddr=%0d required 3 3", wcount, waddr);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_threshold();
      test_wrap();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wptr_full_prog.md
Name: wptr_full_prog

Overview:
- Write-domain pointer and flag block for the async FIFO, a parametrised successor to the existing write-pointer/full logic.
- Keeps the binary and Gray write pointers and registered full detection.
- Adds a runtime-programmable almost-full threshold, a registered fill-level count, and a sticky overflow flag with clear.
- Sits in the write clock domain; the Gray pointer goes to sync_w2r, and the synchronised read pointer comes back from the read-to-write synchroniser.

Parameters:
ADDRSIZE, 4, FIFO address width; DEPTH = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits wide.

Ports:
wclk_i  in  1  write-domain clock
wrst_i  in  1  asynchronous, active-high reset
winc_i  in  1  write request, one word per cycle
wq2_rptr_i  in  ADDRSIZE+1  Gray read pointer, already synchronised to wclk_i
wafull_thr_i  in  ADDRSIZE+1  almost-full threshold in words; 0 disables the flag
wclr_ovf_i  in  1  clear sticky overflow
wptr_o  out  ADDRSIZE+1  registered Gray write pointer
waddr_o  out  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0]
wfull_o  out  1  FIFO full, registered
w_almost_full_o  out  1  fill level >= threshold, registered
wcount_o  out  ADDRSIZE+1  registered fill level, 0..DEPTH
wovf_o  out  1  sticky: a write was attempted while full

Behaviour:
- Reset:
  - Asserting wrst_i immediately forces wbin, wptr_o, wfull_o, w_almost_full_o, wcount_o and wovf_o to 0, with no clock edge needed.
  - Reset mid-operation discards all state.
  - The first write after release goes to address 0.
- Pointer update:
  - wbinnext = wbin + (winc_i & ~wfull_o), modulo 2**(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
  - Both are registered every wclk_i edge.
  - A write is accepted in the cycle where winc_i=1 and wfull_o=0; waddr_o is valid in that same cycle.
- Level:
  - rbin = Gray-to-binary of wq2_rptr_i.
  - lvl_next = (wbinnext - rbin) modulo 2**(ADDRSIZE+1), always in the range 0..DEPTH.
  - wcount_o <= lvl_next, i.e. one cycle of latency after the accepting edge.
  - The level is pessimistic: it lags true reads by the synchroniser delay, but never under-reports.
- Full:
  - wfull_o <= (wgraynext == {~wq2_rptr_i[ADDRSIZE:ADDRSIZE-1], wq2_rptr_i[ADDRSIZE-2:0]}).
  - This is equivalent to lvl_next == DEPTH; the verifier must check the two agree.
  - wfull_o rises on the same edge that accepts the DEPTH-th word.
  - wfull_o falls on the first edge after wq2_rptr_i advances.
- Almost full:
  - thr_eff = min(wafull_thr_i, DEPTH).
  - w_almost_full_o <= (thr_eff != 0) && (lvl_next >= thr_eff).
  - Threshold changes take effect on the next edge.
- Overflow:
  - Set condition: winc_i=1 while wfull_o=1. The write is dropped, the pointer does not move, and wovf_o goes to 1 on that edge.
  - wclr_ovf_i=1 clears wovf_o on the edge.
  - If a set and a clear occur in the same cycle, set wins.
- Wrap-around: the pointer wraps from 2*DEPTH-1 to 0. The extra MSB distinguishes full from empty, and the level arithmetic is modulo, so it is correct across the wrap.
- Simultaneous write and read-pointer advance: both are used in the same lvl_next computation, so no special case is needed.
- There are no other states. The block is pure pointer/flag registers, with no FSM.

Decomposition:
- Package fifo_pkg holds:
  - DEPTH(ADDRSIZE) as a constant function.
  - The bin2gray function.
  - The PTR_W = ADDRSIZE+1 localparam convention.
- Sub-module gray2bin, parameter WIDTH: a combinational XOR prefix that converts the synchronised Gray read pointer. It is reused later by rptr_empty_prog.

Test Plan:
(ADDRSIZE=4, DEPTH=16, wq2_rptr_i=0 unless stated)
1. Hold winc_i=1 through reset -> all outputs 0 during reset; after release wptr_o steps 00000, 00001, 00011, 00010, 00110; waddr_o steps 0,1,2,3.
2. 16 consecutive writes -> after the 16th edge: wfull_o=1, wcount_o=16, wptr_o=11000, waddr_o=0; w_almost_full_o=1 with thr=16.
3. Continue winc_i=1 for 2 cycles while full -> wptr_o stays at 11000 and wovf_o=1 after the first edge. Pulse wclr_ovf_i -> wovf_o=0. Then apply clear and a write attempt together -> wovf_o stays 1.
4. Threshold cases:
   - thr=12, 12 writes -> w_almost_full_o=1 and wcount_o=12 on the same edge; 11 writes -> 0.
   - thr=0 -> w_almost_full_o stays 0 at full.
   - thr=31 -> asserts only at 16.
5. After 16 writes, set wq2_rptr_i=11000 (gray 16) -> next edge wfull_o=0, wcount_o=0. Then 16 more writes -> pointer wraps to 00000 and wfull_o=1 again.
6. At wcount_o=7, assert wrst_i between clock edges -> all outputs 0 within the same cycle; after release, 3 writes -> wcount_o=3 and waddr_o=3.
